// File: rtl/b_pwrmon_seq_v2_if.sv
// ---------------------------------------------------------------------------
// b_pwrmon_seq_v2_if
// Bundles the monitor-facing signals of b_pwrmon_seq_v2 so the converter
// front end and the sequencer share one connection.
//
// Parameter:
//   NumConverters  number of monitored channels N (1..32)
//
// Signals (direction as seen by the slave, i.e. the monitor block):
//   ch_ok        in  [N-1:0]  per-channel in-window indication
//   ch_warn      in  [N-1:0]  per-channel warning-threshold indication
//   eoc_toggle   in           firmware end-of-conversion toggle
//   fault_clr    in           single-cycle clear of latched fault status
//   fault_mask   in  [N-1:0]  only when B_PWRMON_FAULT_MASK_EN is defined
//   fault        out          OR of fault_status
//   warn         out          any warning on a debounced-good channel
//   eoc          out          one-clock pulse per eoc_toggle edge
//   pgood_bus    out [31:0]   debounced power-good
//   fault_status out [31:0]   per-channel fault flags
//
// Modports: master drives the inputs of the monitor, slave is the monitor.
// ---------------------------------------------------------------------------
interface b_pwrmon_seq_v2_if #(
    parameter int NumConverters = 8
);
    logic [NumConverters-1:0] ch_ok;
    logic [NumConverters-1:0] ch_warn;
    logic                     eoc_toggle;
    logic                     fault_clr;
`ifdef B_PWRMON_FAULT_MASK_EN
    logic [NumConverters-1:0] fault_mask;
`endif
    logic                     fault;
    logic                     warn;
    logic                     eoc;
    logic [31:0]              pgood_bus;
    logic [31:0]              fault_status;

`ifdef B_PWRMON_FAULT_MASK_EN
    modport master (
        output ch_ok, ch_warn, eoc_toggle, fault_clr, fault_mask,
        input  fault, warn, eoc, pgood_bus, fault_status
    );
    modport slave (
        input  ch_ok, ch_warn, eoc_toggle, fault_clr, fault_mask,
        output fault, warn, eoc, pgood_bus, fault_status
    );
`else
    modport master (
        output ch_ok, ch_warn, eoc_toggle, fault_clr,
        input  fault, warn, eoc, pgood_bus, fault_status
    );
    modport slave (
        input  ch_ok, ch_warn, eoc_toggle, fault_clr,
        output fault, warn, eoc, pgood_bus, fault_status
    );
`endif
endinterface

// File: rtl/b_pwrmon_seq_v2.sv
// ---------------------------------------------------------------------------
// b_pwrmon_seq_v2
// Power-good monitor / sequencer. Each converter channel is debounced by a
// four-state FSM; channels that have once been good are armed, and an armed
// channel whose debounced pgood drops raises fault status (sticky or live).
// Firmware end-of-conversion toggles are turned into one-clock pulses.
//
// Parameters:
//   NumConverters   channels N, 1..32
//   PgoodConfig     0 = pgood_bus[0] is AND of all channels, 1 = per-channel
//   DebounceCycles  stable samples needed for a pgood change, 1..255
//   FaultLatch      1 = sticky fault status cleared by fault_clr, 0 = live
//
// Ports:
//   clock   sole clock, rising edge
//   reset   synchronous, active-high
//   bus     b_pwrmon_seq_v2_if.slave (ch_ok, ch_warn, eoc_toggle, fault_clr,
//           fault, warn, eoc, pgood_bus, fault_status)
//
// Optional feature: define B_PWRMON_FAULT_MASK_EN to add bus.fault_mask;
// masked channels never set fault status. Debounce and pgood are unaffected.
// ---------------------------------------------------------------------------
module b_pwrmon_seq_v2 #(
    parameter int NumConverters  = 8,
    parameter int PgoodConfig    = 0,
    parameter int DebounceCycles = 4,
    parameter int FaultLatch     = 1
) (
    input logic              clock,
    input logic              reset,
    b_pwrmon_seq_v2_if.slave bus
);

    localparam int         N         = NumConverters;
    localparam logic [7:0] LastCount = 8'(DebounceCycles - 1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        LOW_PEND  = 2'd1,
        HIGH      = 2'd2,
        HIGH_PEND = 2'd3
    } deb_state_t;

    deb_state_t   state_q [N];
    logic [7:0]   count_q [N];
    logic [N-1:0] armed_q;
    logic [N-1:0] pgood_q;
    logic [N-1:0] fault_q;
    logic [N-1:0] fault_event;
    logic [N-1:0] fault_en;
    logic         warn_q;
    logic         eoc_q;
    logic         eoc_prev_q;
    logic [31:0]  pgood_word;
    logic [31:0]  fault_word;

`ifdef B_PWRMON_FAULT_MASK_EN
    assign fault_en = ~bus.fault_mask;
`else
    assign fault_en = '1;
`endif

    // A fault event is the debounced fall of an armed channel. With a
    // one-cycle debounce there is no HIGH_PEND, so the fall is HIGH -> LOW.
    always_comb begin
        fault_event = '0;
        for (int i = 0; i < N; i++) begin
            if (DebounceCycles == 1) begin
                fault_event[i] = (state_q[i] == HIGH) && !bus.ch_ok[i]
                                 && armed_q[i];
            end else begin
                fault_event[i] = (state_q[i] == HIGH_PEND) && !bus.ch_ok[i]
                                 && (count_q[i] == LastCount) && armed_q[i];
            end
        end
    end

    // Per-channel debounce FSMs. pgood_q is a registered copy of
    // "state is HIGH or HIGH_PEND", updated together with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= LOW;
                count_q[i] <= 8'd0;
            end
            armed_q <= '0;
            pgood_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                case (state_q[i])
                    LOW: begin
                        if (bus.ch_ok[i]) begin
                            if (DebounceCycles == 1) begin
                                state_q[i] <= HIGH;
                                pgood_q[i] <= 1'b1;
                                armed_q[i] <= 1'b1;
                            end else begin
                                state_q[i] <= LOW_PEND;
                                count_q[i] <= 8'd1;
                            end
                        end
                    end
                    LOW_PEND: begin
                        if (!bus.ch_ok[i]) begin
                            state_q[i] <= LOW;
                            count_q[i] <= 8'd0;
                        end else if (count_q[i] == LastCount) begin
                            state_q[i] <= HIGH;
                            count_q[i] <= 8'd0;
                            pgood_q[i] <= 1'b1;
                            armed_q[i] <= 1'b1;
                        end else begin
                            count_q[i] <= count_q[i] + 8'd1;
                        end
                    end
                    HIGH: begin
                        if (!bus.ch_ok[i]) begin
                            if (DebounceCycles == 1) begin
                                state_q[i] <= LOW;
                                pgood_q[i] <= 1'b0;
                            end else begin
                                state_q[i] <= HIGH_PEND;
                                count_q[i] <= 8'd1;
                            end
                        end
                    end
                    HIGH_PEND: begin
                        if (bus.ch_ok[i]) begin
                            state_q[i] <= HIGH;
                            count_q[i] <= 8'd0;
                        end else if (count_q[i] == LastCount) begin
                            state_q[i] <= LOW;
                            count_q[i] <= 8'd0;
                            pgood_q[i] <= 1'b0;
                        end else begin
                            count_q[i] <= count_q[i] + 8'd1;
                        end
                    end
                    default: begin
                        state_q[i] <= LOW;
                        count_q[i] <= 8'd0;
                        pgood_q[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Fault status. In sticky mode an event on the same clock as fault_clr
    // wins, so the new fault is never lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q <= '0;
        end else if (FaultLatch != 0) begin
            fault_q <= ((fault_q & ~{N{bus.fault_clr}}) | fault_event)
                       & fault_en;
        end else begin
            fault_q <= armed_q & ~pgood_q & fault_en;
        end
    end

    // Warning and end-of-conversion pulse. During reset the edge detector
    // tracks eoc_toggle so that releasing reset never produces a pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            warn_q     <= 1'b0;
            eoc_q      <= 1'b0;
            eoc_prev_q <= bus.eoc_toggle;
        end else begin
            warn_q     <= |(bus.ch_warn & pgood_q);
            eoc_q      <= bus.eoc_toggle ^ eoc_prev_q;
            eoc_prev_q <= bus.eoc_toggle;
        end
    end

    always_comb begin
        pgood_word = '0;
        fault_word = '0;
        if (PgoodConfig == 1) begin
            pgood_word[N-1:0] = pgood_q;
        end else begin
            pgood_word[0] = &pgood_q;
        end
        fault_word[N-1:0] = fault_q;
    end

    assign bus.pgood_bus    = pgood_word;
    assign bus.fault_status = fault_word;
    assign bus.fault        = |fault_q;
    assign bus.warn         = warn_q;
    assign bus.eoc          = eoc_q;

endmodule

// File: tb/tb_b_pwrmon_seq_v2.sv
// ---------------------------------------------------------------------------
// tb_b_pwrmon_seq_v2
// Two monitor instances:
//   dut_a  N=4, per-channel pgood bus, 4-cycle debounce, sticky faults
//   dut_b  N=3, combined pgood, 1-cycle debounce, live faults
// The stimulus process drives directed vectors and queues the hand-computed
// responses with the cycle they are due; the monitor process pops and
// compares them one time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_b_pwrmon_seq_v2;

    localparam int SEL_A_PG   = 0;
    localparam int SEL_A_FS   = 1;
    localparam int SEL_A_F    = 2;
    localparam int SEL_A_EOC  = 3;
    localparam int SEL_A_WARN = 4;
    localparam int SEL_B_PG   = 5;
    localparam int SEL_B_FS   = 6;
    localparam int SEL_B_F    = 7;

    typedef struct {
        int          cyc;
        int          sel;
        int          id;
        logic [31:0] exp;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    exp_t sb[$];
    int   cyc       = 0;
    int   next_id   = 0;
    int   checks    = 0;
    int   errors    = 0;

    b_pwrmon_seq_v2_if #(.NumConverters(4)) a_if ();
    b_pwrmon_seq_v2_if #(.NumConverters(3)) b_if ();

    b_pwrmon_seq_v2 #(
        .NumConverters (4),
        .PgoodConfig   (1),
        .DebounceCycles(4),
        .FaultLatch    (1)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (a_if.slave)
    );

    b_pwrmon_seq_v2 #(
        .NumConverters (3),
        .PgoodConfig   (0),
        .DebounceCycles(1),
        .FaultLatch    (0)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (b_if.slave)
    );

    always #5 clock = ~clock;

    function automatic string sel_name(input int sel);
        case (sel)
            SEL_A_PG:   return "a_pgood_bus";
            SEL_A_FS:   return "a_fault_status";
            SEL_A_F:    return "a_fault";
            SEL_A_EOC:  return "a_eoc";
            SEL_A_WARN: return "a_warn";
            SEL_B_PG:   return "b_pgood_bus";
            SEL_B_FS:   return "b_fault_status";
            default:    return "b_fault";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_A_PG:   return a_if.pgood_bus;
            SEL_A_FS:   return a_if.fault_status;
            SEL_A_F:    return {31'd0, a_if.fault};
            SEL_A_EOC:  return {31'd0, a_if.eoc};
            SEL_A_WARN: return {31'd0, a_if.warn};
            SEL_B_PG:   return b_if.pgood_bus;
            SEL_B_FS:   return b_if.fault_status;
            default:    return {31'd0, b_if.fault};
        endcase
    endfunction

    // Queue an expected value due n rising edges from now.
    task automatic expect_at(input int n, input int sel, input logic [31:0] v);
        exp_t e;
        int   pos;
        e.cyc = cyc + n;
        e.sel = sel;
        e.id  = next_id;
        e.exp = v;
        next_id++;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > e.cyc) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        act = actual(e.sel);
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s #%0d at cycle %0d: actual=%h required=%h",
                     sel_name(e.sel), e.id, cyc, act, e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus();
        // Reset state of both instances.
        step(1);
        expect_at(1, SEL_A_PG, 32'h0);
        expect_at(1, SEL_A_FS, 32'h0);
        expect_at(1, SEL_A_F, 32'h0);
        expect_at(1, SEL_A_EOC, 32'h0);
        expect_at(1, SEL_A_WARN, 32'h0);
        expect_at(1, SEL_B_PG, 32'h0);
        expect_at(1, SEL_B_FS, 32'h0);
        expect_at(1, SEL_B_F, 32'h0);

        // Release reset with eoc_toggle already high: no pulse.
        step(1);
        reset = 1'b0;
        expect_at(1, SEL_A_EOC, 32'h0);
        expect_at(2, SEL_A_EOC, 32'h0);
        step(2);

        // Three-clock glitch on channel 1 never reaches pgood.
        a_if.ch_ok = 4'b0010;
        expect_at(3, SEL_A_PG, 32'h0);
        expect_at(4, SEL_A_PG, 32'h0);
        step(3);
        a_if.ch_ok = 4'b0000;
        expect_at(1, SEL_A_PG, 32'h0);
        expect_at(3, SEL_A_PG, 32'h0);
        step(3);

        // Channel 0 rises: pgood exactly 4 clocks later, warn one after that.
        a_if.ch_ok   = 4'b0001;
        a_if.ch_warn = 4'b0001;
        expect_at(3, SEL_A_PG, 32'h0);
        expect_at(4, SEL_A_PG, 32'h1);
        expect_at(4, SEL_A_WARN, 32'h0);
        expect_at(5, SEL_A_WARN, 32'h1);
        step(5);
        a_if.ch_warn = 4'b0000;
        expect_at(1, SEL_A_WARN, 32'h0);

        // Channels 1 and 2 join.
        a_if.ch_ok = 4'b0111;
        expect_at(3, SEL_A_PG, 32'h1);
        expect_at(4, SEL_A_PG, 32'h7);
        step(6);

        // Channel 1 drops for 4 clocks: sticky fault on bit 1.
        a_if.ch_ok = 4'b0101;
        expect_at(3, SEL_A_PG, 32'h7);
        expect_at(3, SEL_A_FS, 32'h0);
        expect_at(4, SEL_A_PG, 32'h5);
        expect_at(4, SEL_A_FS, 32'h2);
        expect_at(4, SEL_A_F, 32'h1);
        expect_at(8, SEL_A_F, 32'h1);
        step(8);

        // Channel 2 faults on the same clock fault_clr is sampled.
        a_if.ch_ok = 4'b0001;
        expect_at(3, SEL_A_FS, 32'h2);
        step(3);
        a_if.fault_clr = 1'b1;
        expect_at(1, SEL_A_FS, 32'h4);
        expect_at(1, SEL_A_F, 32'h1);
        expect_at(1, SEL_A_PG, 32'h1);
        step(1);
        a_if.fault_clr = 1'b0;
        expect_at(2, SEL_A_FS, 32'h4);
        step(2);

        // Plain clear; channel 3 was never good and must stay unflagged.
        a_if.fault_clr = 1'b1;
        expect_at(1, SEL_A_FS, 32'h0);
        expect_at(1, SEL_A_F, 32'h0);
        step(1);
        a_if.fault_clr = 1'b0;
        expect_at(6, SEL_A_FS, 32'h0);

        // eoc_toggle 1->0->1 on consecutive clocks: two back-to-back pulses.
        a_if.eoc_toggle = 1'b0;
        expect_at(1, SEL_A_EOC, 32'h1);
        expect_at(2, SEL_A_EOC, 32'h1);
        expect_at(3, SEL_A_EOC, 32'h0);
        step(1);
        a_if.eoc_toggle = 1'b1;
        step(4);

        // Instance B: unarmed channels never fault, combined pgood.
        expect_at(1, SEL_B_F, 32'h0);
        expect_at(1, SEL_B_FS, 32'h0);
        b_if.ch_ok = 3'b011;
        expect_at(1, SEL_B_PG, 32'h0);
        expect_at(2, SEL_B_PG, 32'h0);
        step(2);
        b_if.ch_ok = 3'b111;
        expect_at(1, SEL_B_PG, 32'h1);
        step(2);

        // Live fault status follows armed & !pgood one clock behind pgood.
        b_if.ch_ok = 3'b101;
        expect_at(1, SEL_B_PG, 32'h0);
        expect_at(1, SEL_B_FS, 32'h0);
        expect_at(2, SEL_B_FS, 32'h2);
        expect_at(2, SEL_B_F, 32'h1);
        step(2);
        b_if.fault_clr = 1'b1;
        expect_at(1, SEL_B_FS, 32'h2);
        step(1);
        b_if.fault_clr = 1'b0;
        b_if.ch_ok     = 3'b111;
        expect_at(1, SEL_B_PG, 32'h1);
        expect_at(1, SEL_B_FS, 32'h2);
        expect_at(2, SEL_B_FS, 32'h0);
        step(3);

        // Reset in the middle of channel 0's falling debounce: no fault.
        a_if.ch_ok = 4'b0000;
        expect_at(2, SEL_A_PG, 32'h1);
        step(2);
        reset = 1'b1;
        expect_at(1, SEL_A_PG, 32'h0);
        expect_at(1, SEL_A_FS, 32'h0);
        step(2);
        reset = 1'b0;
        expect_at(1, SEL_A_EOC, 32'h0);
        expect_at(4, SEL_A_FS, 32'h0);
        expect_at(4, SEL_A_F, 32'h0);
        step(6);

`ifdef B_PWRMON_FAULT_MASK_EN
        // Masked channel 0 drops: pgood follows, fault status does not.
        a_if.ch_ok = 4'b0001;
        expect_at(4, SEL_A_PG, 32'h1);
        step(6);
        a_if.ch_ok = 4'b0000;
        expect_at(3, SEL_A_PG, 32'h1);
        expect_at(4, SEL_A_PG, 32'h0);
        expect_at(4, SEL_A_FS, 32'h0);
        expect_at(5, SEL_A_F, 32'h0);
        step(6);
`endif
    endtask

    // Monitor: compare every queued expectation that has come due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        a_if.ch_ok      = '0;
        a_if.ch_warn    = '0;
        a_if.eoc_toggle = 1'b1;
        a_if.fault_clr  = 1'b0;
        b_if.ch_ok      = '0;
        b_if.ch_warn    = '0;
        b_if.eoc_toggle = 1'b0;
        b_if.fault_clr  = 1'b0;
`ifdef B_PWRMON_FAULT_MASK_EN
        a_if.fault_mask = 4'b0001;
        b_if.fault_mask = 3'b000;
`endif
        applyStimulus();

        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            @(negedge clock);
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s #%0d never compared: actual=%h required=%h",
                     sel_name(e.sel), e.id, actual(e.sel), e.exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/b_pwrmon_seq_v2.md
B_PWRMON_SEQ_V2 -- requirements
Module: b_pwrmon_seq_v2

Interface
REQ-001 SHALL provide parameter NumConverters, default 8, number of monitored channels N, legal 1..32.
REQ-002 SHALL provide parameter PgoodConfig, default 0; 0 = single combined pgood, 1 = per-channel pgood bus.
REQ-003 SHALL provide parameter DebounceCycles, default 4, stable-sample count for pgood change, legal 1..255.
REQ-004 SHALL provide parameter FaultLatch, default 1; 1 = sticky fault status, 0 = live fault status.
REQ-005 clock  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ch_ok  input  N  per-channel in-window indication, synchronous to clock.
REQ-008 ch_warn  input  N  per-channel warning-threshold indication, synchronous to clock.
REQ-009 eoc_toggle  input  1  firmware end-of-conversion toggle; each edge denotes one completed scan.
REQ-010 fault_clr  input  1  single-cycle pulse clearing latched fault status.
REQ-011 fault  output  1  OR of fault_status.
REQ-012 warn  output  1  registered OR of (ch_warn AND debounced pgood).
REQ-013 eoc  output  1  single-cycle pulse per eoc_toggle edge.
REQ-014 pgood_bus  output  32  debounced power-good, format per PgoodConfig.
REQ-015 fault_status  output  32  per-channel fault flags, bits N..31 tied 0.

Function
REQ-016 Each channel SHALL run a 4-state debounce FSM: LOW, LOW_PEND, HIGH, HIGH_PEND, with an 8-bit stable counter.
REQ-017 LOW: ch_ok=1 -> LOW_PEND, counter=1; ch_ok=0 -> stay.
REQ-018 LOW_PEND: ch_ok=0 -> LOW, counter=0; ch_ok=1 and counter=DebounceCycles-1 -> HIGH; else counter+1.
REQ-019 HIGH/HIGH_PEND SHALL mirror REQ-017/018 with ch_ok inverted.
REQ-020 DebounceCycles=1 SHALL bypass pending states: debounced pgood equals ch_ok delayed one clock.
REQ-021 Debounced pgood[i] SHALL be 1 in HIGH and HIGH_PEND, 0 otherwise; a change is visible DebounceCycles clocks after the first differing sample.
REQ-022 Channel armed[i] SHALL set on first entry to HIGH; cleared only by reset.
REQ-023 Fault event[i] SHALL be HIGH_PEND->LOW transition with armed[i]=1.
REQ-024 FaultLatch=1: fault_status[i] sets on fault event, clears on fault_clr; simultaneous event and fault_clr -> bit set.
REQ-025 FaultLatch=0: fault_status[i] = armed[i] AND NOT pgood[i], registered; fault_clr ignored.
REQ-026 eoc SHALL assert exactly one clock, the clock after an eoc_toggle edge is sampled; back-to-back edges give back-to-back pulses.
REQ-027 PgoodConfig=0: pgood_bus[0] = AND of all N debounced pgood bits, bits 31:1 = 0.
REQ-028 PgoodConfig=1: pgood_bus[N-1:0] = debounced pgood, upper bits 0; N=32 uses all bits.
REQ-029 All outputs SHALL be register-driven; no combinational input-to-output path.

Reset
REQ-030 During reset all FSMs SHALL enter LOW, counters 0, armed 0, fault_status 0, fault/warn/eoc/pgood_bus 0.
REQ-031 During reset the eoc edge-detect register SHALL load eoc_toggle so no pulse follows reset release.
REQ-032 Reset asserted mid-debounce SHALL abandon the pending count; no fault event generated.

Configuration
REQ-033 Macro B_PWRMON_FAULT_MASK_EN defined: adds input fault_mask[N-1:0]; masked channels never set fault_status and contribute 0 to fault; debounce and pgood unaffected.
REQ-034 Macro undefined: no fault_mask port; all channels fault-enabled.

Verification
REQ-035 N=4, Debounce=4: ch_ok[0] 0->1 held -> pgood_bus[0] bus mode rises exactly 4 clocks later; 3-clock glitch -> no change.
REQ-036 Channel 1 good, then ch_ok[1]=0 for 4 clocks, FaultLatch=1 -> fault_status=0x2, fault=1 until fault_clr; fault_clr same cycle as channel 2 fault -> fault_status=0x4.
REQ-037 Channel never good, ch_ok=0 -> fault stays 0 (unarmed).
REQ-038 eoc_toggle 0->1->0 on consecutive clocks -> eoc high two consecutive clocks; reset released with eoc_toggle=1 -> eoc stays 0.
REQ-039 PgoodConfig=0, N=3, channels 0,1 good, 2 low -> pgood_bus=0x0; all good -> 0x1.
REQ-040 FAULT_MASK_EN with fault_mask=0x1, channel 0 drops -> fault_status=0, fault=0, pgood_bus[0]=0.
